bus_slave: RTL and testbench
============================

# bus_slave

Responder end of the system-bus transaction protocol driven by the bus masters. Decodes the master's address, performs one byte-wide read or write into a local memory after a programmable number of wait cycles, and returns `rdata`/`sl_valid`, holding the response until the master drops `m_valid`. One instance sits behind the bus mux per slave slot, selected by the top address nibble.

## Interface
- `SLAVE_ID`, 4'h0: matches `addr[15:12]`; only matching requests are accepted.
- `MEM_DEPTH`, 256: bytes of local memory, 1..4096.
- `WAIT_CYCLES`, 2: extra cycles between accept and memory operation, 0..15.

Ports:
- `clk`  in  1  bus clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `addr`  in  16  master address, stable while `m_valid`=1.
- `wdata`  in  8  write data, stable while `m_valid`=1.
- `mode`  in  1  1 = write, 0 = read.
- `m_valid`  in  1  master request valid; held until the master sees `sl_valid`.
- `rdata`  out  8  read data; valid while `sl_valid`=1 for reads.
- `sl_valid`  out  1  response valid.
- `sl_err`  out  1  qualifies `sl_valid`: index out of range.
- `sl_ready`  out  1  1 in IDLE (can accept a request).
- `state_show`  out  2  current FSM state, debug.

## Operation
- Reset (async assert, sync release): state IDLE; `sl_valid`=0, `sl_err`=0, `rdata`=8'h00, `sl_ready`=1, `state_show`=2'b00, wait counter 0. Memory contents not reset.
- Hit = `m_valid` && `addr[15:12]`==`SLAVE_ID`. Index = `addr[11:0]`; out of range when index >= `MEM_DEPTH`.
- IDLE (2'b00): on hit, latch addr/wdata/mode, counter <= `WAIT_CYCLES`, go WAIT. Non-hit requests ignored.
- WAIT (2'b01): counter != 0 -> decrement. Counter == 0 -> perform op, go RESP:
  - write in range: mem[index] <= wdata; `rdata` <= 8'h00; `sl_err` <= 0.
  - read in range: `rdata` <= mem[index]; `sl_err` <= 0.
  - out of range: write dropped; `rdata` <= 8'hFF; `sl_err` <= 1.
- RESP (2'b10): `sl_valid`=1, `rdata`/`sl_err` held. On the first edge sampling `m_valid`=0: go IDLE, `sl_valid`<=0, `sl_err`<=0, `rdata` held.
- `m_valid` dropping during WAIT (master abort): op still completes; RESP exits on the next edge since `m_valid` is already 0. A committed write is never rolled back.
- Inputs are not re-sampled in WAIT/RESP; changes to `addr`/`wdata`/`mode` after accept have no effect.
- Reset mid-transaction: immediate return to IDLE, outputs to reset values; a write whose op edge has not occurred is lost.

## Timing
- Accept at edge E0 -> op at edge E0+1+`WAIT_CYCLES` -> `sl_valid`=1 from that edge. With defaults: `sl_valid` 3 cycles after accept.
- Master clears `m_valid` the cycle after seeing `sl_valid`; the slave sees 0 one edge later and returns to IDLE. `sl_valid` is therefore high for exactly 2 cycles with a conforming master.
- Back-to-back: a new hit is accepted on the first edge in IDLE, i.e. 1 cycle after `sl_valid` falls. `sl_valid` is never high on the IDLE cycle, so a master's stale-response check cannot see a false response.
- Memory: synchronous write, registered read; no combinational path from inputs to outputs.

## Structure
- `bus_pkg`: `MODE_READ`=1'b0, `MODE_WRITE`=1'b1, the slave state enum (IDLE/WAIT/RESP with the encodings above), `ERR_RDATA`=8'hFF, address field widths (ID [15:12], index [11:0]).
- Sub-module `slave_mem`: single-port synchronous RAM, parameter `MEM_DEPTH`, 8-bit data, write enable + registered read. FSM, decode and counter stay in `bus_slave`.

## Test plan
- Write 16'h0010 <- 8'hA5 (`SLAVE_ID`=0, defaults), then read 16'h0010 -> `rdata`=8'hA5, `sl_err`=0, `sl_valid` rises 3 cycles after each accept and stays 2 cycles.
- Request to 16'h1010 with `SLAVE_ID`=0 -> no accept: `sl_ready` stays 1, `sl_valid` stays 0 for 20 cycles.
- Read 16'h0100 with `MEM_DEPTH`=256 -> `sl_valid`=1, `sl_err`=1, `rdata`=8'hFF. Prior write there is dropped; mem[0] unchanged.
- `WAIT_CYCLES`=0: back-to-back writes to 0x0001/0x0002 then reads -> `sl_valid` 1 cycle after accept, data 0x11/0x22 returned. Second accept 1 cycle after `sl_valid` falls.
- Abort: drop `m_valid` during WAIT on a write of 8'h3C to 0x0005 -> `sl_valid` high 1 cycle, return to IDLE. A later read returns 8'h3C.
- Assert `rst_n`=0 mid-WAIT on write of 8'h77 to 0x0006 (mem holds 8'h00) -> outputs reset asynchronously, state 2'b00. A later read returns 8'h00.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus slave: transfer modes, FSM encoding,
// error read data and address field layout.
package bus_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } slave_state_t;

    localparam logic [7:0] ERR_RDATA = 8'hFF;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;
    localparam int IDX_W  = 12;
    localparam int CNT_W  = 4;

    function automatic logic [ID_W-1:0] addr_id(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: ID_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port byte RAM: synchronous write, registered read.
module slave_mem
    import bus_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // No reset on storage or read register; the owner decides when rdata is meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_slave.sv
// Bus responder: decodes the slave ID, waits WAIT_CYCLES, performs one byte
// access into local memory and holds the response until m_valid drops.
module bus_slave
    import bus_pkg::*;
#(
    parameter logic [3:0] SLAVE_ID    = 4'h0,
    parameter int         MEM_DEPTH   = 256,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        mode,
    input  logic        m_valid,
    output logic [7:0]  rdata,
    output logic        sl_valid,
    output logic        sl_err,
    output logic        sl_ready,
    output logic [1:0]  state_show
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    slave_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       wdata_q;
    logic             mode_q;
    logic [7:0]       rdata_q;
    logic [7:0]       mem_rdata;
    logic             use_mem_q;
    logic             valid_q;
    logic             err_q;
    logic             hit;
    logic             accept;
    logic             do_op;
    logic             in_range;
    logic             mem_we;
    logic             mem_re;

    assign hit      = m_valid && (addr_id(addr) == SLAVE_ID);
    assign in_range = ({20'd0, idx_q} < MEM_DEPTH);
    assign mem_we   = do_op && in_range && (mode_q == MODE_WRITE);
    assign mem_re   = do_op && in_range && (mode_q == MODE_READ);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        do_op   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    do_op   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!m_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(WAIT_CYCLES);
        end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Request fields are captured once at accept; later bus activity is ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= addr_idx(addr);
            wdata_q <= wdata;
            mode_q  <= mode;
        end
    end

    // Response registers. Reads are served from the RAM read register, which
    // only updates on the op edge, so rdata stays held after RESP exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            use_mem_q <= 1'b0;
        end else if (do_op) begin
            valid_q <= 1'b1;
            if (!in_range) begin
                err_q     <= 1'b1;
                rdata_q   <= ERR_RDATA;
                use_mem_q <= 1'b0;
            end else if (mode_q == MODE_WRITE) begin
                err_q     <= 1'b0;
                rdata_q   <= 8'h00;
                use_mem_q <= 1'b0;
            end else begin
                err_q     <= 1'b0;
                use_mem_q <= 1'b1;
            end
        end else if (state_q == ST_RESP && !m_valid) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    slave_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (idx_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign rdata      = use_mem_q ? mem_rdata : rdata_q;
    assign sl_valid   = valid_q;
    assign sl_err     = err_q;
    assign sl_ready   = (state_q == ST_IDLE);
    assign state_show = state_q;

endmodule

// File: tb/tb_bus_slave.sv
// Testbench for bus_slave: table of transactions on a WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 instance, scoreboard queue, plus non-hit, abort and reset sequences.
module tb_bus_slave;

    typedef struct {
        int         sel;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        mode;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        mode = 1'b0;
    logic        m_valid0 = 1'b0;
    logic        m_valid1 = 1'b0;

    logic [7:0]  rdata0, rdata1;
    logic        sl_valid0, sl_valid1;
    logic        sl_err0, sl_err1;
    logic        sl_ready0, sl_ready1;
    logic [1:0]  state0, state1;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    bus_slave dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mode(mode),
        .m_valid(m_valid0), .rdata(rdata0), .sl_valid(sl_valid0), .sl_err(sl_err0),
        .sl_ready(sl_ready0), .state_show(state0)
    );

    bus_slave #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mode(mode),
        .m_valid(m_valid1), .rdata(rdata1), .sl_valid(sl_valid1), .sl_err(sl_err1),
        .sl_ready(sl_ready1), .state_show(state1)
    );

    function automatic logic vld(input int s);
        return (s != 0) ? sl_valid1 : sl_valid0;
    endfunction
    function automatic logic rdy(input int s);
        return (s != 0) ? sl_ready1 : sl_ready0;
    endfunction
    function automatic logic errf(input int s);
        return (s != 0) ? sl_err1 : sl_err0;
    endfunction
    function automatic logic [7:0] rd(input int s);
        return (s != 0) ? rdata1 : rdata0;
    endfunction
    function automatic logic [1:0] st(input int s);
        return (s != 0) ? state1 : state0;
    endfunction

    task automatic set_mv(input int s, input logic v);
        if (s != 0) m_valid1 = v;
        else        m_valid0 = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Wait for sl_valid, counting edges since the accept edge; returns 0 on timeout.
    task automatic wait_resp(input int s, output int lat, output bit seen);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (vld(s)) seen = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!seen) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_resp(input int s, input int lat);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("rdata", 32'(rd(s)), 32'(e.rdata));
        check("sl_err", 32'(errf(s)), 32'(e.err));
        check("latency", 32'(lat), 32'(e.lat));
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        bit seen;
        exp_t e;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        check("ready_before", 32'(rdy(v.sel)), 32'd1);
        addr  = v.addr;
        wdata = v.wdata;
        mode  = v.mode;
        set_mv(v.sel, 1'b1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        check("accept_state", 32'(st(v.sel)), 32'd1);
        // Bus fields change after accept; the slave must not notice.
        addr  = 16'($urandom);
        wdata = 8'($urandom);
        mode  = 1'($urandom);
        wait_resp(v.sel, lat, seen);
        if (!seen) begin
            set_mv(v.sel, 1'b0);
            void'(exp_q.pop_front());
            return;
        end
        compare_resp(v.sel, lat);
        @(posedge clk); #1;
        check("valid_hold", 32'(vld(v.sel)), 32'd1);
        check("rdata_hold", 32'(rd(v.sel)), 32'(v.exp_rdata));
        set_mv(v.sel, 1'b0);
        @(posedge clk); #1;
        check("valid_fall", 32'(vld(v.sel)), 32'd0);
        check("err_fall", 32'(errf(v.sel)), 32'd0);
        check("ready_after", 32'(rdy(v.sel)), 32'd1);
        check("rdata_after", 32'(rd(v.sel)), 32'(v.exp_rdata));
    endtask

    function automatic vec_t mk(input int s, input logic [15:0] a, input logic [7:0] d,
                                input logic m, input logic [7:0] er, input logic ee, input int el);
        vec_t v;
        v.sel = s; v.addr = a; v.wdata = d; v.mode = m;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    initial begin
        int lat;
        bit seen;
        exp_t e;

        // WAIT_CYCLES=2 slave: latency 3; WAIT_CYCLES=0 slave: latency 1.
        vecs.push_back(mk(0, 16'h0010, 8'hA5, 1'b1, 8'h00, 1'b0, 3));
        vecs.push_back(mk(0, 16'h0010, 8'h00, 1'b0, 8'hA5, 1'b0, 3));
        vecs.push_back(mk(0, 16'h0000, 8'hC3, 1'b1, 8'h00, 1'b0, 3));
        vecs.push_back(mk(0, 16'h0100, 8'h5A, 1'b1, 8'hFF, 1'b1, 3));
        vecs.push_back(mk(0, 16'h0100, 8'h00, 1'b0, 8'hFF, 1'b1, 3));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 1'b0, 8'hC3, 1'b0, 3));
        vecs.push_back(mk(0, 16'h00FF, 8'h96, 1'b1, 8'h00, 1'b0, 3));
        vecs.push_back(mk(0, 16'h00FF, 8'h00, 1'b0, 8'h96, 1'b0, 3));
        vecs.push_back(mk(0, 16'h0FFF, 8'h00, 1'b0, 8'hFF, 1'b1, 3));
        vecs.push_back(mk(1, 16'h0001, 8'h11, 1'b1, 8'h00, 1'b0, 1));
        vecs.push_back(mk(1, 16'h0002, 8'h22, 1'b1, 8'h00, 1'b0, 1));
        vecs.push_back(mk(1, 16'h0001, 8'h00, 1'b0, 8'h11, 1'b0, 1));
        vecs.push_back(mk(1, 16'h0002, 8'h00, 1'b0, 8'h22, 1'b0, 1));

        #1;
        check("rst_valid", 32'(sl_valid0), 32'd0);
        check("rst_err", 32'(sl_err0), 32'd0);
        check("rst_rdata", 32'(rdata0), 32'd0);
        check("rst_ready", 32'(sl_ready0), 32'd1);
        check("rst_state", 32'(state0), 32'd0);
        check("rst_state1", 32'(state1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Other slave ID: never accepted.
        addr  = 16'h1010;
        wdata = 8'h55;
        mode  = 1'b1;
        m_valid0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("nohit_ready", 32'(sl_ready0), 32'd1);
            check("nohit_valid", 32'(sl_valid0), 32'd0);
        end
        m_valid0 = 1'b0;
        @(posedge clk); #1;

        // Abort during WAIT: write still lands, response lasts one cycle.
        addr  = 16'h0005;
        wdata = 8'h3C;
        mode  = 1'b1;
        m_valid0 = 1'b1;
        e.rdata = 8'h00; e.err = 1'b0; e.lat = 3;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check("abort_accept", 32'(state0), 32'd1);
        m_valid0 = 1'b0;
        wait_resp(0, lat, seen);
        if (seen) begin
            compare_resp(0, lat);
            @(posedge clk); #1;
            check("abort_valid_fall", 32'(sl_valid0), 32'd0);
            check("abort_state", 32'(state0), 32'd0);
        end else begin
            void'(exp_q.pop_front());
        end
        run_txn(mk(0, 16'h0005, 8'h00, 1'b0, 8'h3C, 1'b0, 3));

        // Reset in WAIT loses the pending write; rdata is A5 going in.
        run_txn(mk(0, 16'h0006, 8'h00, 1'b1, 8'h00, 1'b0, 3));
        run_txn(mk(0, 16'h0010, 8'h00, 1'b0, 8'hA5, 1'b0, 3));
        addr  = 16'h0006;
        wdata = 8'h77;
        mode  = 1'b1;
        m_valid0 = 1'b1;
        @(posedge clk); #1;
        check("rstmid_accept", 32'(state0), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_state", 32'(state0), 32'd0);
        check("rstmid_valid", 32'(sl_valid0), 32'd0);
        check("rstmid_err", 32'(sl_err0), 32'd0);
        check("rstmid_rdata", 32'(rdata0), 32'd0);
        check("rstmid_ready", 32'(sl_ready0), 32'd1);
        m_valid0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(mk(0, 16'h0006, 8'h00, 1'b0, 8'h00, 1'b0, 3));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
